// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Owns the single register-file write port between execute and writeback.
//   Single-cycle results (ALU, PC+4) are written one cycle after acceptance.
//   Loads and CSR reads stall the pipeline until their response arrives, and
//   are then written one cycle after the response.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ex_valid_i          execute stage retires an instruction this cycle
//   ex_wb_type_i        00 ALU, 01 load, 10 PC+4, 11 CSR
//   ex_rf_en_i, ex_rd_i instruction writes rd / destination register
//   lsu_rsp_valid_i     load data valid (handshake with lsu_rsp_ready_o)
//   lsu_rsp_ready_o     load data accepted (only in WAIT_LOAD)
//   csr_rsp_valid_i     CSR read data valid, consumed in WAIT_CSR
//   wb_sel_o            writeback mux select (registered)
//   rf_we_o, rf_waddr_o register-file write enable / address (registered)
//   stall_o             freeze PC/IF/EX while a multi-cycle result is pending
//   pend_valid_o        a qualified multi-cycle writeback is outstanding
//   pend_rd_o           rd of the outstanding writeback (holds when idle)
//   err_o               one-cycle pulse when a wait is abandoned
//
// Build option
//   WB_TIMEOUT_EN       when defined, a wait is abandoned after WB_TIMEOUT
//                       cycles without a response; otherwise waits forever
//                       and err_o is constant 0.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | accepting instructions; single-cycle types write next cycle
// ST_WAIT_LD| load outstanding, stalled, waiting for lsu_rsp_valid_i
// ST_WAIT_CS| CSR read outstanding, stalled, waiting for csr_rsp_valid_i
module wb_port_arbiter #(
  parameter int unsigned WB_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_valid_i,
  input  logic [1:0] ex_wb_type_i,
  input  logic       ex_rf_en_i,
  input  logic [4:0] ex_rd_i,
  input  logic       lsu_rsp_valid_i,
  output logic       lsu_rsp_ready_o,
  input  logic       csr_rsp_valid_i,
  output logic [1:0] wb_sel_o,
  output logic       rf_we_o,
  output logic [4:0] rf_waddr_o,
  output logic       stall_o,
  output logic       pend_valid_o,
  output logic [4:0] pend_rd_o,
  output logic       err_o
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_CSR  = 2'b11;

  if ((WB_TIMEOUT < 2) || (WB_TIMEOUT > 65535)) begin : g_bad_timeout
    $error("wb_port_arbiter: WB_TIMEOUT must be in 2..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT_LD = 2'b01,
    ST_WAIT_CS = 2'b10
  } state_t;

  state_t     r_state;
  logic [4:0] r_cap_rd;
  logic       r_cap_en;
  logic [1:0] r_wb_sel;
  logic       r_rf_we;
  logic [4:0] r_rf_waddr;
  logic       r_err;

  logic w_ex_qual;
  logic w_cap_qual;
  logic w_ex_multi;
  logic w_expired;

  assign w_ex_qual  = ex_rf_en_i && (ex_rd_i != 5'd0);
  assign w_cap_qual = r_cap_en && (r_cap_rd != 5'd0);
  // Type bit 0 set means load or CSR: both need a response before writing.
  assign w_ex_multi = ex_wb_type_i[0];

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(WB_TIMEOUT - 1);
  logic [15:0] r_cnt;

  // Held at zero while idle so every wait starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= 16'd0;
    else if (r_state == ST_IDLE)
      r_cnt <= 16'd0;
    else
      r_cnt <= r_cnt + 16'd1;
  end

  assign w_expired = (r_cnt == CNT_LAST);
  assign err_o     = r_err;
`else
  assign w_expired = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cap_rd   <= 5'd0;
      r_cap_en   <= 1'b0;
      r_wb_sel   <= WB_ALU;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_err      <= 1'b0;
    end else begin
      r_rf_we    <= 1'b0;
      r_wb_sel   <= WB_ALU;
      r_rf_waddr <= 5'd0;
      r_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ex_valid_i) begin
            if (w_ex_multi) begin
              r_cap_rd <= ex_rd_i;
              r_cap_en <= ex_rf_en_i;
              r_state  <= (ex_wb_type_i == WB_CSR) ? ST_WAIT_CS : ST_WAIT_LD;
            end else if (w_ex_qual) begin
              r_rf_we    <= 1'b1;
              r_wb_sel   <= ex_wb_type_i;
              r_rf_waddr <= ex_rd_i;
            end
          end
        end
        ST_WAIT_LD: begin
          // A response on the expiry cycle still completes normally.
          if (lsu_rsp_valid_i) begin
            r_rf_we    <= w_cap_qual;
            r_wb_sel   <= w_cap_qual ? WB_LOAD : WB_ALU;
            r_rf_waddr <= w_cap_qual ? r_cap_rd : 5'd0;
            r_state    <= ST_IDLE;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT_CS: begin
          if (csr_rsp_valid_i) begin
            r_rf_we    <= w_cap_qual;
            r_wb_sel   <= w_cap_qual ? WB_CSR : WB_ALU;
            r_rf_waddr <= w_cap_qual ? r_cap_rd : 5'd0;
            r_state    <= ST_IDLE;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wb_sel_o        = r_wb_sel;
  assign rf_we_o         = r_rf_we;
  assign rf_waddr_o      = r_rf_waddr;
  assign stall_o         = (r_state != ST_IDLE);
  assign lsu_rsp_ready_o = (r_state == ST_WAIT_LD);
  assign pend_valid_o    = (r_state != ST_IDLE) && w_cap_qual;
  assign pend_rd_o       = r_cap_rd;

endmodule
